// File: rtl/core_pkg.sv
// Shared types and widths for the core pipeline stages.
package core_pkg;
    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Bundle handed to the MEM/WB register.
    typedef struct packed {
        logic [WORD_W-1:0]     alu_result;
        logic [WORD_W-1:0]     mem_data;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  reg_w;
        logic                  mem_to_reg;
    } memwb_t;

    // A bubble writes nothing back; all fields are driven to zero.
    localparam memwb_t MEMWB_BUBBLE = '0;
endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has waited; expired once MAX_WAIT is reached.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    // Wait counter, updated on the falling edge like the pipeline registers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (enable) cnt <= cnt + CW'(1);
    end

    assign expired = (cnt == CW'(MAX_WAIT));
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: performs loads/stores over a req/ack data-memory port, stalls
// upstream while an access is outstanding, and drives the MEM/WB bundle.
module mem_access_stage
    import core_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_W-1:0]     ALU_result_in,
    input  logic [WORD_W-1:0]     Mem_w_data_in,
    input  logic [REG_ADDR_W-1:0] Rd_addr_in,
    input  logic                  Reg_w_in,
    input  logic                  Mem_r_in,
    input  logic                  Mem_w_in,
    input  logic                  Mem_to_reg_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WORD_W-1:0]     dmem_addr,
    output logic [WORD_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [WORD_W-1:0]     dmem_rdata,
    output logic                  stall,
    output logic [WORD_W-1:0]     Mem_data_out,
    output logic [WORD_W-1:0]     ALU_result_out,
    output logic [REG_ADDR_W-1:0] Rd_addr_out,
    output logic                  Reg_w_out,
    output logic                  Mem_to_reg_out,
    output logic                  mem_err
);
    mem_state_t            state_q, state_d;
    memwb_t                out_q;
    logic [REG_ADDR_W-1:0] lat_rd;
    logic                  lat_reg_w, lat_m2r;
    logic                  access, misaligned, expired;

    assign access     = Mem_r_in | Mem_w_in;
    assign misaligned = |ALU_result_in[1:0];

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   ((state_q != BUSY) | dmem_ack | expired),
        .enable  ((state_q == BUSY) & ~dmem_ack),
        .expired (expired)
    );

    // Stall holds the access in EX/MEM until it completes; a timeout releases it
    // so the dropped instruction is not reissued. Reset forces it low at once.
    assign stall = rst_n & (((state_q == IDLE) & access & ~misaligned) |
                            ((state_q == BUSY) & ~dmem_ack & ~expired));

    // State register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: start on an aligned access, finish on ack or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (access && !misaligned) state_d = BUSY;
            BUSY: if (dmem_ack || expired)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request port, latched instruction fields, MEM/WB bundle and sticky error.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            lat_rd     <= '0;
            lat_reg_w  <= 1'b0;
            lat_m2r    <= 1'b0;
            out_q      <= MEMWB_BUBBLE;
            mem_err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!access) begin
                        out_q.alu_result <= ALU_result_in;
                        out_q.mem_data   <= '0;
                        out_q.rd_addr    <= Rd_addr_in;
                        out_q.reg_w      <= Reg_w_in;
                        out_q.mem_to_reg <= Mem_to_reg_in;
                    end else if (misaligned) begin
                        mem_err <= 1'b1;
                        out_q   <= MEMWB_BUBBLE;
                    end else begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= Mem_w_in;  // load+store together counts as store
                        dmem_addr  <= ALU_result_in;
                        dmem_wdata <= Mem_w_data_in;
                        lat_rd     <= Rd_addr_in;
                        lat_reg_w  <= Reg_w_in;
                        lat_m2r    <= Mem_to_reg_in;
                        out_q      <= MEMWB_BUBBLE;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req         <= 1'b0;
                        out_q.alu_result <= dmem_addr;
                        out_q.mem_data   <= dmem_we ? '0 : dmem_rdata;
                        out_q.rd_addr    <= lat_rd;
                        out_q.reg_w      <= lat_reg_w & ~dmem_we;
                        out_q.mem_to_reg <= lat_m2r;
                    end else begin
                        out_q <= MEMWB_BUBBLE;
                        if (expired) begin
                            dmem_req <= 1'b0;
                            mem_err  <= 1'b1;
                        end
                    end
                end
                default: out_q <= MEMWB_BUBBLE;
            endcase
        end
    end

    assign ALU_result_out = out_q.alu_result;
    assign Mem_data_out   = out_q.mem_data;
    assign Rd_addr_out    = out_q.rd_addr;
    assign Reg_w_out      = out_q.reg_w;
    assign Mem_to_reg_out = out_q.mem_to_reg;
endmodule
